// File: rtl/sub_bytes_sequencer.sv
// Byte-serial AES SubBytes engine. Captures a 128-bit state on start, then
// pushes one substituted byte per cycle into the 16x8 SubBytes state RAM
// through its write port. A one-cycle done pulse follows the last commit.
module sub_bytes_sequencer #(
   parameter bit INVERSE = 1'b0  // 0 = forward S-box (encrypt), 1 = inverse S-box (decrypt)
) (
   input  logic         clk,
   input  logic         rst,       // asynchronous, active-low
   input  logic         start,
   input  logic [127:0] state_in,
   input  logic         stall,
   output logic [7:0]   wr_data,
   output logic [3:0]   wr_addr,
   output logic         wr_en,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // FIPS-197 forward S-box, entry 0 in the most significant byte.
   localparam logic [0:255][7:0] FWD_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // The inverse table is derived from the forward one at elaboration, so the
   // two can never disagree; either way the hardware is a single constant ROM.
   function automatic logic [0:255][7:0] build_table(input bit inv);
      logic [0:255][7:0] t;
      t = '0;
      for (int i = 0; i < 256; i++) begin
         if (inv) t[FWD_SBOX[i]] = 8'(i);
         else     t[i]           = FWD_SBOX[i];
      end
      return t;
   endfunction

   localparam logic [0:255][7:0] SBOX = build_table(INVERSE);

   state_t           state, state_nxt;
   logic [3:0]       cnt;
   logic [0:15][7:0] captured;   // index 0 = state_in[127:120]
   logic [7:0]       sub_byte;

   // Combinational lookup of the current byte; registered into wr_data.
   assign sub_byte = SBOX[captured[cnt]];

   // State register.
   // NOTE: every clocked process uses non-blocking assignments so all
   // registers update together from values sampled before the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state decode: a pass runs until the edge that issues byte 15.
   // NOTE: the default assignment first keeps this block free of latches
   // for any path the case statement does not cover.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (!stall && cnt == 4'd15) state_nxt = FLUSH;
         FLUSH:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and registered outputs: capture, per-byte write issue, done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         captured <= '0;
         wr_data  <= '0;
         wr_addr  <= '0;
         wr_en    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  captured <= state_in;
                  cnt      <= '0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               // A stalled edge holds cnt, wr_data and wr_addr; wr_en drops.
               if (!stall) begin
                  wr_data <= sub_byte;
                  wr_addr <= cnt;
                  wr_en   <= 1'b1;
                  cnt     <= cnt + 4'd1;
               end
            end
            FLUSH: begin
               // The RAM commits byte 15 on this edge; announce completion.
               done <= 1'b1;
            end
            DONE: begin
               busy <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sub_bytes_sequencer.sv
// Scoreboard bench for sub_bytes_sequencer: one forward and one inverse
// instance share clock, reset and stall. Expected writes are queued when a
// pass is accepted and compared as each wr_en pulse appears.
module tb_sub_bytes_sequencer;

   typedef logic [0:15][7:0] bytes_t;
   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   localparam bytes_t FWD_IN  = 128'h00112233445566778899aabbccddeeff;
   localparam bytes_t FWD_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
   localparam bytes_t ALT_IN  = 128'hdeadbeef0123456789abcdeffedcba98;
   localparam bytes_t S53_IN  = {16{8'h53}};
   localparam bytes_t S53_OUT = {16{8'hed}};

   logic             clk;
   logic             rst;
   logic             stall;
   logic [1:0]       start;
   logic [1:0][127:0] state_in;
   logic [1:0][7:0]  wr_data;
   logic [1:0][3:0]  wr_addr;
   logic [1:0]       wr_en;
   logic [1:0]       busy;
   logic [1:0]       done;

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   exp_t q0[$];
   exp_t q1[$];
   int   exp_done[2];
   int   wr_count[2];
   bit   done_seen[2];

   sub_bytes_sequencer #(.INVERSE(1'b0)) dut_fwd (
      .clk(clk), .rst(rst), .start(start[0]), .state_in(state_in[0]), .stall(stall),
      .wr_data(wr_data[0]), .wr_addr(wr_addr[0]), .wr_en(wr_en[0]),
      .busy(busy[0]), .done(done[0])
   );

   sub_bytes_sequencer #(.INVERSE(1'b1)) dut_inv (
      .clk(clk), .rst(rst), .start(start[1]), .state_in(state_in[1]), .stall(stall),
      .wr_data(wr_data[1]), .wr_addr(wr_addr[1]), .wr_en(wr_en[1]),
      .busy(busy[1]), .done(done[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_exp(input int inst, input exp_t e);
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
   endtask

   function automatic int q_size(input int inst);
      return (inst == 0) ? q0.size() : q1.size();
   endfunction

   task automatic pop_exp(input int inst, output exp_t e, output bit ok);
      ok = 1'b0;
      e  = '{addr: '0, data: '0, cyc: 0};
      if (inst == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      if (inst == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
   endtask

   // Monitor: compare every write and done pulse against the scoreboard.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (wr_en[i]) begin
            exp_t e;
            bit   ok;
            pop_exp(i, e, ok);
            wr_count[i]++;
            if (!ok) check($sformatf("extra_wr%0d", i), 32'(wr_addr[i]), 32'hffff_ffff);
            else begin
               check($sformatf("wr_addr%0d", i), 32'(wr_addr[i]), 32'(e.addr));
               check($sformatf("wr_data%0d", i), 32'(wr_data[i]), 32'(e.data));
               check($sformatf("wr_cyc%0d", i),  32'(cyc),        32'(e.cyc));
            end
         end
         if (done[i]) begin
            done_seen[i] = 1'b1;
            check($sformatf("done_cyc%0d", i), 32'(cyc), 32'(exp_done[i]));
         end
      end
   end

   // Launch a pass on one instance and queue its 16 expected writes.
   // Write k lands k+1 cycles after the accepting edge; a stall after write
   // stall_after pushes every later write and done back by three cycles.
   task automatic start_pass(input int inst, input bytes_t st, input bytes_t exp,
                             input int stall_after, output int acc);
      int slip;
      @(negedge clk);
      state_in[inst] = st;
      start[inst]    = 1'b1;
      @(posedge clk);
      #1;
      start[inst]     = 1'b0;
      acc             = cyc;
      done_seen[inst] = 1'b0;
      wr_count[inst]  = 0;
      for (int k = 0; k < 16; k++) begin
         slip = (stall_after >= 0 && k > stall_after) ? 3 : 0;
         push_exp(inst, '{addr: 4'(k), data: exp[k], cyc: acc + 1 + k + slip});
      end
      exp_done[inst] = acc + 17 + ((stall_after >= 0) ? 3 : 0);
      if (stall_after >= 0) begin
         @(negedge clk);
         for (int n = 0; n < 40 && cyc != acc + 1 + stall_after; n++) @(negedge clk);
         stall = 1'b1;
         repeat (3) @(negedge clk);
         stall = 1'b0;
      end
   endtask

   // Wait (bounded) for done, then confirm busy drops and the pass was complete.
   task automatic wait_done(input int inst);
      for (int n = 0; n < 60 && !done_seen[inst]; n++) begin
         @(negedge clk);
         #1;
      end
      check($sformatf("done_seen%0d", inst), 32'(done_seen[inst]), 32'd1);
      check($sformatf("busy_in_done%0d", inst), 32'(busy[inst]), 32'd1);
      @(negedge clk);
      #1;
      check($sformatf("busy_after%0d", inst), 32'(busy[inst]), 32'd0);
      check($sformatf("wr_count%0d", inst), 32'(wr_count[inst]), 32'd16);
      check($sformatf("sb_empty%0d", inst), 32'(q_size(inst)), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int acc;
      rst         = 1'b0;
      stall       = 1'b0;
      start       = 2'b11;
      state_in[0] = FWD_IN;
      state_in[1] = FWD_OUT;
      exp_done[0] = -1;
      exp_done[1] = -1;
      wr_count[0] = 0;
      wr_count[1] = 0;

      // 1: reset held with start asserted -> everything stays quiet.
      repeat (3) begin
         @(negedge clk);
         check("rst_busy",  32'(busy),  32'd0);
         check("rst_wr_en", 32'(wr_en), 32'd0);
         check("rst_done",  32'(done),  32'd0);
      end
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      start = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // 2: forward pass, no stall.
      start_pass(0, FWD_IN, FWD_OUT, -1, acc);
      wait_done(0);

      // 3: inverse pass on the forward result recovers the original state.
      start_pass(1, FWD_OUT, FWD_IN, -1, acc);
      wait_done(1);

      // 4: three stall cycles after the addr-5 write.
      start_pass(0, FWD_IN, FWD_OUT, 5, acc);
      wait_done(0);

      // 5: second start mid-pass with a different state is ignored.
      start_pass(0, FWD_IN, FWD_OUT, -1, acc);
      while (cyc != acc + 4) @(negedge clk);
      state_in[0] = ALT_IN;
      start[0]    = 1'b1;
      @(negedge clk);
      start[0]    = 1'b0;
      wait_done(0);
      repeat (25) @(negedge clk);
      check("no_second_pass", 32'(busy[0]), 32'd0);

      // 6: asynchronous reset mid-pass, then a fresh pass of all 0x53.
      start_pass(0, FWD_IN, FWD_OUT, -1, acc);
      while (cyc != acc + 7) @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_wr_en",   32'(wr_en[0]),   32'd0);
      check("abort_busy",    32'(busy[0]),    32'd0);
      check("abort_wr_data", 32'(wr_data[0]), 32'd0);
      check("abort_wr_addr", 32'(wr_addr[0]), 32'd0);
      q0.delete();
      exp_done[0] = -1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_abort_idle", 32'(busy[0]), 32'd0);
      start_pass(0, S53_IN, S53_OUT, -1, acc);
      wait_done(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
